// File: rtl/cpu_irqrcv.sv
// cpu_irqrcv: PIMC interrupt message receiver with a pending-line FIFO.
// Optional duplicate-line suppression: define CPU_IRQRCV_DEDUP_EN.
module cpu_irqrcv #(
    parameter logic [7:0] CPU_ID     = 8'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       notify,
    input  logic [7:0] lineno,
    input  logic [7:0] processor_id,
    output logic       irqack,
    output logic       irq_valid,
    output logic [7:0] irq_line,
    input  logic       irq_take,
    output logic       overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic            r_irqack;
    logic            r_overflow;
    logic            r_valid;
    logic [7:0]      r_line;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_mem [FIFO_DEPTH];

    logic            w_match;
    logic            w_full;
    logic            w_dup;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic [PW-1:0]   w_rptr_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_valid_n;
    logic [7:0]      w_line_n;

`ifdef CPU_IRQRCV_DEDUP_EN
    // Compare the incoming line against every live queue entry.
    always_comb begin
        logic [PW-1:0] idx;
        w_dup = 1'b0;
        idx   = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = r_rptr + PW'(i);
            if ((CW'(i) < r_count) && (r_mem[idx] == lineno))
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Decide push/pop and precompute the next queue head.
    always_comb begin
        w_match   = !rst && (r_state == S_IDLE) && !notify
                    && (processor_id == CPU_ID);
        w_full    = (r_count == CW'(FIFO_DEPTH));
        w_accept  = w_match && (w_dup || !w_full);
        w_push    = w_accept && !w_dup;
        w_ovf_set = w_match && !w_dup && w_full;
        w_pop     = irq_take && (r_count != '0);
        w_rptr_n  = w_pop ? (r_rptr + 1'b1) : r_rptr;
        w_cnt_n   = r_count;
        if (w_push && !w_pop)
            w_cnt_n = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_n = r_count - 1'b1;
        w_valid_n = (w_cnt_n != '0);
        w_line_n  = 8'h00;
        if (w_valid_n) begin
            if (w_push && (w_rptr_n == r_wptr))
                w_line_n = lineno;
            else
                w_line_n = r_mem[w_rptr_n];
        end
    end

    // Handshake FSM with registered acknowledge and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_irqack   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ovf_set)
                r_overflow <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    r_irqack <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_ACK;
                        r_irqack <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state  <= S_RELEASE;
                    r_irqack <= 1'b0;
                end
                S_RELEASE: begin
                    r_irqack <= 1'b0;
                    if (notify)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_irqack <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers, occupancy and registered head view.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_line  <= 8'h00;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            r_rptr  <= w_rptr_n;
            r_count <= w_cnt_n;
            r_valid <= w_valid_n;
            r_line  <= w_line_n;
        end
    end

    // Queue storage; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= lineno;
    end

    assign irqack    = r_irqack;
    assign irq_valid = r_valid;
    assign irq_line  = r_line;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cpu_irqrcv.sv
// tb_cpu_irqrcv: directed checks of the cpu_irqrcv handshake and queue.
// Expectations follow CPU_IRQRCV_DEDUP_EN when the bench is built with it.
module tb_cpu_irqrcv;

    logic       clk;
    logic       rst;
    logic       notify;
    logic [7:0] lineno;
    logic [7:0] processor_id;
    logic       irqack;
    logic       irq_valid;
    logic [7:0] irq_line;
    logic       irq_take;
    logic       overflow;

    int checks;
    int failures;

    cpu_irqrcv #(
        .CPU_ID    (8'h00),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .notify      (notify),
        .lineno      (lineno),
        .processor_id(processor_id),
        .irqack      (irqack),
        .irq_valid   (irq_valid),
        .irq_line    (irq_line),
        .irq_take    (irq_take),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one message for one cycle, then release; returns the ack seen.
    task automatic send(input logic [7:0] line, input logic [7:0] pid,
                        output logic ack);
        notify       = 1'b0;
        lineno       = line;
        processor_id = pid;
        tick();
        ack    = irqack;
        notify = 1'b1;
        tick();
        tick();
    endtask

    task automatic pop();
        irq_take = 1'b1;
        tick();
        irq_take = 1'b0;
    endtask

    logic       ack;
    logic       seen_ack;
    logic       seen_valid;
    logic [7:0] exp_line [4];

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        notify       = 1'b1;
        lineno       = 8'h00;
        processor_id = 8'h00;
        irq_take     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_irqack", irqack, 0);
        chk("rst_valid", irq_valid, 0);
        chk("rst_line", irq_line, 0);
        chk("rst_ovf", overflow, 0);

        // Basic capture; notify stays low through ACK and RELEASE.
        notify = 1'b0;
        lineno = 8'd5;
        tick();
        chk("b_ack1", irqack, 1);
        chk("b_valid", irq_valid, 1);
        chk("b_line", irq_line, 5);
        tick();
        chk("b_ack2", irqack, 0);
        tick();
        chk("b_ack3", irqack, 0);
        notify = 1'b1;
        tick();
        tick();
        pop();
        chk("b_single", irq_valid, 0);
        chk("b_empty_line", irq_line, 0);

        // Message for another processor is ignored.
        notify       = 1'b0;
        lineno       = 8'd7;
        processor_id = 8'd3;
        seen_ack     = 1'b0;
        seen_valid   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_ack   = seen_ack | irqack;
            seen_valid = seen_valid | irq_valid;
        end
        chk("o_ack", seen_ack, 0);
        chk("o_valid", seen_valid, 0);
        notify       = 1'b1;
        processor_id = 8'd0;
        tick();

        // Fill the queue, then a fifth message waits for space.
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 8'd0, ack);
            chk("f_ack", ack, 1);
        end
        chk("f_head", irq_line, 1);
        notify = 1'b0;
        lineno = 8'd9;
        tick();
        chk("f_noack", irqack, 0);
        chk("f_ovf", overflow, 1);
        tick();
        chk("f_noack2", irqack, 0);
        irq_take = 1'b1;
        tick();
        irq_take = 1'b0;
        chk("f_nobypass", irqack, 0);
        chk("f_head2", irq_line, 2);
        tick();
        chk("f_late_ack", irqack, 1);
        notify = 1'b1;
        tick();
        tick();
        exp_line[0] = 8'd2;
        exp_line[1] = 8'd3;
        exp_line[2] = 8'd4;
        exp_line[3] = 8'd9;
        for (int i = 0; i < 4; i++) begin
            chk("f_order_v", irq_valid, 1);
            chk("f_order", irq_line, exp_line[i]);
            pop();
        end
        chk("f_drained", irq_valid, 0);
        chk("f_sticky", overflow, 1);

        // Simultaneous push and pop with one entry queued.
        send(8'd8, 8'd0, ack);
        chk("s_ack0", ack, 1);
        notify   = 1'b0;
        lineno   = 8'd6;
        irq_take = 1'b1;
        tick();
        irq_take = 1'b0;
        notify   = 1'b1;
        chk("s_ack", irqack, 1);
        chk("s_valid", irq_valid, 1);
        chk("s_line", irq_line, 6);
        tick();
        tick();
        pop();
        chk("s_count1", irq_valid, 0);

        // Pop on an empty queue changes nothing.
        pop();
        chk("e_valid", irq_valid, 0);
        send(8'd2, 8'd0, ack);
        chk("e_line", irq_line, 2);
        pop();
        chk("e_valid2", irq_valid, 0);

        // Same line twice.
        send(8'd5, 8'd0, ack);
        chk("d_ack1", ack, 1);
        send(8'd5, 8'd0, ack);
        chk("d_ack2", ack, 1);
        chk("d_line", irq_line, 5);
        pop();
`ifdef CPU_IRQRCV_DEDUP_EN
        chk("d_entries", irq_valid, 0);
`else
        chk("d_entries", irq_valid, 1);
        chk("d_line2", irq_line, 5);
        pop();
        chk("d_empty", irq_valid, 0);
`endif

        // Reset while in ACK.
        send(8'd1, 8'd0, ack);
        notify = 1'b0;
        lineno = 8'd3;
        tick();
        chk("r_inack", irqack, 1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        notify = 1'b1;
        chk("r_ack", irqack, 0);
        chk("r_valid", irq_valid, 0);
        chk("r_ovf", overflow, 0);
        tick();
        chk("r_noack", irqack, 0);
        send(8'd4, 8'd0, ack);
        chk("r_idle", ack, 1);
        chk("r_line", irq_line, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_irqrcv.md
CPU_IRQRCV -- requirements
Module: cpu_irqrcv

Interface
REQ-001 SHALL have parameter CPU_ID, default 8'h00: processor identifier this receiver answers to.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: pending-line queue depth, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous to clk, active-high.
REQ-005 SHALL have port notify  input  1  PIMC message strobe; low = message presented, high = idle.
REQ-006 SHALL have port lineno  input  8  PIMC IRQ line number, valid while notify low.
REQ-007 SHALL have port processor_id  input  8  PIMC target processor, valid while notify low.
REQ-008 SHALL have port irqack  output  1  one-cycle acknowledge pulse to PIMC.
REQ-009 SHALL have port irq_valid  output  1  queue non-empty; a line is pending for the core.
REQ-010 SHALL have port irq_line  output  8  line number at queue head; 8'h00 when empty.
REQ-011 SHALL have port irq_take  input  1  core pops the head entry this cycle.
REQ-012 SHALL have port overflow  output  1  sticky; set when a message waited on a full queue.

Function
REQ-013 SHALL implement FSM states IDLE, ACK, RELEASE.
REQ-014 In IDLE with notify==0, processor_id==CPU_ID and queue not full: push lineno, go to ACK next cycle.
REQ-015 In IDLE with notify==0 and processor_id!=CPU_ID: no push, no ack, stay IDLE.
REQ-016 In IDLE with a matching message and queue full: no push, no ack, set overflow, stay IDLE until space frees.
REQ-017 ACK SHALL drive irqack=1 for exactly one cycle, then go to RELEASE.
REQ-018 RELEASE SHALL hold irqack=0 and return to IDLE on the first cycle notify==1; no capture in RELEASE.
REQ-019 Message-to-irqack latency SHALL be exactly 1 cycle after the capture edge, given space.
REQ-020 irq_line/irq_valid SHALL reflect the queue head registered; a push is visible on irq_valid the cycle after capture.
REQ-021 irq_take with irq_valid==0 SHALL be ignored; no pointer or count change.
REQ-022 Simultaneous push and pop SHALL both occur; count unchanged; full/empty computed on pre-update count (no bypass into a full queue).
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-024 Queue order SHALL be strictly FIFO.
REQ-025 overflow SHALL clear only on rst.

Reset
REQ-026 On rst: FSM=IDLE, irqack=0, irq_valid=0, irq_line=8'h00, overflow=0, pointers and count=0, contents discarded.
REQ-027 rst SHALL take priority over all other inputs, including mid-handshake (ACK or RELEASE); no irqack pulse after rst.

Configuration
REQ-028 Macro CPU_IRQRCV_DEDUP_EN SHALL select duplicate suppression.
REQ-029 With CPU_IRQRCV_DEDUP_EN defined: a matching message whose lineno equals any valid queued entry SHALL be acked normally but not pushed; applies even when queue full (acked, no overflow).
REQ-030 Without CPU_IRQRCV_DEDUP_EN: every accepted message SHALL be pushed; no comparators synthesized.

Verification
REQ-031 CPU_ID=0: notify=0, processor_id=0, lineno=5 -> irqack high 1 cycle later for 1 cycle; irq_valid=1, irq_line=5.
REQ-032 processor_id=3, lineno=7, notify held low 10 cycles -> irqack never asserts, irq_valid stays 0.
REQ-033 Four messages lines 1,2,3,4 (notify toggled between) then fifth line 9 -> first four acked, fifth unacked, overflow=1; irq_take once -> line 9 acked, pops yield 2,3,4,9.
REQ-034 Queue holding 1 entry, push of line 6 and irq_take same cycle -> count stays 1, irq_line=6 next cycle.
REQ-035 rst asserted in ACK state -> irqack=0 next cycle, irq_valid=0, FSM IDLE, overflow=0.
REQ-036 DEDUP_EN defined: line 5 sent twice -> two acks, one queue entry; undefined -> two entries.
